// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gray_conv_arbiter
// Brief    : Two-requester arbiter that registers a binary word together with
//            its Gray code and holds it until the consumer accepts it.
//            Define GRAY_ARB_ROUND_ROBIN_EN for round-robin grant; by default
//            requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module gray_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_bin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_bin,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_id
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]       r_state;
  logic             r_last_grant;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_gray;
  logic [WIDTH-1:0] r_out_bin;
  logic             r_out_id;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept0;
  logic             w_accept1;
  logic [WIDTH-1:0] w_sel_bin;

  // Grants exist only in IDLE and never while reset is asserted.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == S_IDLE && !rst) begin
`ifdef GRAY_ARB_ROUND_ROBIN_EN
      if (req0_valid && req1_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
`else
      w_grant0 = req0_valid;
      w_grant1 = req1_valid & ~req0_valid;
`endif
    end
  end

`ifndef GRAY_ARB_ROUND_ROBIN_EN
  // last_grant is tracked but does not steer fixed-priority arbitration.
  logic w_unused_last_grant;
  assign w_unused_last_grant = r_last_grant;
`endif

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign w_accept0  = req0_valid & w_grant0;
  assign w_accept1  = req1_valid & w_grant1;
  assign w_sel_bin  = w_accept1 ? req1_bin : req0_bin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_gray   <= '0;
      r_out_bin    <= '0;
      r_out_id     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept0 || w_accept1) begin
            r_out_bin    <= w_sel_bin;
            r_out_gray   <= w_sel_bin ^ (w_sel_bin >> 1);
            r_out_id     <= w_accept1;
            r_last_grant <= w_accept1;
            r_out_valid  <= 1'b1;
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_gray  = r_out_gray;
  assign out_bin   = r_out_bin;
  assign out_id    = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_conv_arbiter
// Brief    : Self-checking bench for gray_conv_arbiter with directed scenarios
//            and a randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_conv_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         req0_valid;
  logic [W-1:0] req0_bin;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_bin;
  logic         req1_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gray;
  logic [W-1:0] out_bin;
  logic         out_id;

  int n_cmp;
  int n_err;

`ifdef GRAY_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  gray_conv_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_bin  (req0_bin),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_bin  (req1_bin),
    .req1_ready(req1_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_bin   (out_bin),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gray code bit by bit: each bit is the XOR of itself and the next higher bit.
  function automatic logic [W-1:0] ref_gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    for (int i = 0; i < W; i++)
      g[i] = (i == W - 1) ? b[i] : (b[i] != b[i+1]);
    return g;
  endfunction

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Offer a word on one requester and wait for the handshake.
  task automatic send(input bit id, input logic [W-1:0] data);
    bit got = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_bin = data; end
    else    begin req0_valid = 1'b1; req0_bin = data; end
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
      @(posedge clk); #1;
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout id=%0d data=%0d: ready never seen, required within 20 cycles", id, data);
    end
  endtask

  task automatic test_reset;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_bin = 4'd7; req1_bin = 4'd8;
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready});
    end
    n_cmp++;
    if ({out_valid, out_gray, out_bin, out_id} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got v=%b g=%b b=%b id=%b required all 0",
                        out_valid, out_gray, out_bin, out_id);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    send(1'b0, 4'd6);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_gray, out_bin, out_id} !== {1'b1, 4'b0101, 4'd6, 1'b0}) begin
      n_err++; $display("FAIL single: got v=%b g=%b b=%0d id=%b required v=1 g=0101 b=6 id=0",
                        out_valid, out_gray, out_bin, out_id);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_gray} !== {1'b0, 4'b0101}) begin
      n_err++; $display("FAIL single_release: got v=%b g=%b required v=0 g=0101", out_valid, out_gray);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep;
    logic [W-1:0] tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send(1'b1, W'(k));
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_gray, out_bin, out_id} !== {1'b1, tbl[k], W'(k), 1'b1}) begin
        n_err++; $display("FAIL sweep[%0d]: got v=%b g=%b b=%0d id=%b required v=1 g=%b b=%0d id=1",
                          k, out_valid, out_gray, out_bin, out_id, tbl[k], k);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention;
    int k = 0;
    bit exp_id;
    apply_reset(2);
    req0_valid = 1'b1; req0_bin = 4'd3;
    req1_valid = 1'b1; req1_bin = 4'd12;
    out_ready  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!RR) begin
        n_cmp++;
        if (req1_ready !== 1'b0) begin
          n_err++; $display("FAIL contention_ready1 cyc=%0d: got %b required 0", c, req1_ready);
        end
      end
      if (out_valid === 1'b1) begin
        exp_id = RR ? k[0] : 1'b0;
        n_cmp++;
        if ({out_id, out_gray} !== {exp_id, exp_id ? 4'b1010 : 4'b0010}) begin
          n_err++; $display("FAIL contention[%0d]: got id=%b g=%b required id=%b g=%b",
                            k, out_id, out_gray, exp_id, exp_id ? 4'b1010 : 4'b0010);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (k != 4) begin
      n_err++; $display("FAIL contention_count: got %0d results required 4", k);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int hs = 0;
    out_ready = 1'b0;
    send(1'b0, 4'd9);
    req1_valid = 1'b1; req1_bin = 4'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_gray, req0_ready, req1_ready} !== {1'b1, 4'b1101, 2'b00}) begin
        n_err++; $display("FAIL backpressure cyc=%0d: got v=%b g=%b rdy=%b%b required v=1 g=1101 rdy=00",
                          c, out_valid, out_gray, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
    end
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) hs++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (hs != 1) begin
      n_err++; $display("FAIL backpressure_handshakes: got %0d required 1", hs);
    end
  endtask

  task automatic test_reset_mid_hold;
    out_ready = 1'b0;
    send(1'b0, 4'd5);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL midhold_pre: got v=%b required 1", out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_gray, out_bin, out_id} !== '0) begin
      n_err++; $display("FAIL midhold_reset: got v=%b g=%b b=%b id=%b required all 0",
                        out_valid, out_gray, out_bin, out_id);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1'b1, 4'd15);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_gray, out_bin, out_id} !== {1'b1, 4'b1000, 4'd15, 1'b1}) begin
      n_err++; $display("FAIL midhold_after: got v=%b g=%b b=%0d id=%b required v=1 g=1000 b=15 id=1",
                        out_valid, out_gray, out_bin, out_id);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Transaction-level model: requesters keep offering a word until it is taken;
  // the arbiter holds one result at a time and picks a winner by rule.
  task automatic test_random;
    bit           p_v [2];
    logic [W-1:0] p_d [2];
    bit           m_hold, m_last, m_id, has_win, win;
    logic [W-1:0] m_bin, m_gray;
    out_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    apply_reset(2);
    p_v[0] = 0; p_v[1] = 0; p_d[0] = '0; p_d[1] = '0;
    m_hold = 0; m_last = 1; m_id = 0; m_bin = '0; m_gray = '0;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++)
        if (!p_v[n] && ($urandom_range(0, 2) != 0)) begin
          p_v[n] = 1'b1; p_d[n] = W'($urandom);
        end
      req0_valid = p_v[0]; req0_bin = p_d[0];
      req1_valid = p_v[1]; req1_bin = p_d[1];
      out_ready  = ($urandom_range(0, 3) != 0);
      has_win = !m_hold && (p_v[0] || p_v[1]);
      if (p_v[0] && p_v[1]) win = RR ? !m_last : 1'b0;
      else                  win = p_v[1];
      @(negedge clk);
      n_cmp++;
      if ({out_valid, req0_ready, req1_ready, out_gray, out_bin, out_id} !==
          {m_hold, has_win && !win, has_win && win, m_gray, m_bin, m_id}) begin
        n_err++;
        $display("FAIL random cyc=%0d: got v=%b r0=%b r1=%b g=%b b=%b id=%b required v=%b r0=%b r1=%b g=%b b=%b id=%b",
                 c, out_valid, req0_ready, req1_ready, out_gray, out_bin, out_id,
                 m_hold, has_win && !win, has_win && win, m_gray, m_bin, m_id);
      end
      @(posedge clk); #1;
      if (has_win) begin
        m_hold = 1; m_id = win; m_last = win;
        m_bin = p_d[win]; m_gray = ref_gray(p_d[win]);
        p_v[win] = 1'b0;
      end else if (m_hold && out_ready) begin
        m_hold = 0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_bin = '0; req1_bin = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_single;
    test_sweep;
    test_contention;
    test_backpressure;
    test_reset_mid_hold;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
